// File: rtl/erasable_ram_ctrl.sv
// erasable_ram_ctrl
// Synchronous initiator for the asynchronous 16-bit erasable SRAM. It turns
// single-word read/write requests into an E_/W_/G_/UB_/LB_ strobe sequence
// (SETUP -> STROBE -> HOLD -> DONE) and returns lane-masked read data with
// a one-cycle completion pulse. Every pad-facing output is taken straight
// from a flop. The flops are loaded from a decode of the *next* state, so
// each output changes exactly when the state does. W_/G_ can never overlap
// with each other, and G_ can never overlap with the DQ output enable.

module erasable_ram_ctrl #(
    parameter int ADDR_W  = 11,
    parameter int T_SETUP = 1,
    parameter int T_PULSE = 2,
    parameter int T_HOLD  = 1
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST,

    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    input  logic [1:0]        be,
    output logic              ready,
    output logic              done,
    output logic [15:0]       rdata,

    output logic              ram_e_n,
    output logic              ram_w_n,
    output logic              ram_g_n,
    output logic              ram_ub_n,
    output logic              ram_lb_n,
    output logic [15:0]       ram_a,
    output logic [15:0]       ram_dq_out,
    output logic              ram_dq_oe,
    input  logic [15:0]       ram_dq_in
);

    // A zero-length phase would let W_/G_ move in the same cycle as the
    // address or E_, so it is refused at elaboration time.
    if (T_SETUP < 1) begin : g_bad_setup
        $error("erasable_ram_ctrl: T_SETUP must be at least 1");
    end
    if (T_PULSE < 1) begin : g_bad_pulse
        $error("erasable_ram_ctrl: T_PULSE must be at least 1");
    end
    if (T_HOLD < 1) begin : g_bad_hold
        $error("erasable_ram_ctrl: T_HOLD must be at least 1");
    end
    if (ADDR_W < 1 || ADDR_W > 16) begin : g_bad_addr_w
        $error("erasable_ram_ctrl: ADDR_W must be in 1..16");
    end

    // The phase counter loads with (T - 1), so it only has to reach the
    // largest of the three phase lengths minus one.
    localparam int MAX_SP = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int MAX_T  = (MAX_SP > T_HOLD) ? MAX_SP : T_HOLD;
    localparam int CNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        state;
    logic [2:0]        nxt_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  nxt_cnt;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [1:0]        be_q;
    logic [15:0]       cap_q;

    logic              accept;
    logic              last_tick;
    logic              nxt_we;
    logic [ADDR_W-1:0] nxt_addr;
    logic [15:0]       nxt_wdata;
    logic [1:0]        nxt_be;
    logic              nxt_busy;
    logic [15:0]       lane_mask;

    // ready is only ever high in IDLE, so this is the single acceptance point.
    assign accept    = req && ready;
    assign last_tick = (cnt == '0);
    assign lane_mask = {{8{be_q[1]}}, {8{be_q[0]}}};

    // Next-state and phase-counter logic. Each timed phase is left when the
    // counter reaches zero, and the counter is reloaded for the next phase.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    nxt_state = S_SETUP;
                    nxt_cnt   = CNT_W'(T_SETUP - 1);
                end
            end
            S_SETUP: begin
                if (last_tick) begin
                    nxt_state = S_STROBE;
                    nxt_cnt   = CNT_W'(T_PULSE - 1);
                end else begin
                    nxt_cnt   = cnt - 1'b1;
                end
            end
            S_STROBE: begin
                if (last_tick) begin
                    nxt_state = S_HOLD;
                    nxt_cnt   = CNT_W'(T_HOLD - 1);
                end else begin
                    nxt_cnt   = cnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (last_tick) begin
                    nxt_state = S_DONE;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt   = cnt - 1'b1;
                end
            end
            S_DONE: begin
                nxt_state = S_IDLE;
                nxt_cnt   = '0;
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    // The output decode uses the request fields as they will be after this
    // edge. On the acceptance edge that means the live inputs, so SETUP
    // drives the new address in its very first cycle.
    always_comb begin
        nxt_we    = accept ? we    : we_q;
        nxt_addr  = accept ? addr  : addr_q;
        nxt_wdata = accept ? wdata : wdata_q;
        nxt_be    = accept ? be    : be_q;
        nxt_busy  = (nxt_state == S_SETUP) || (nxt_state == S_STROBE) ||
                    (nxt_state == S_HOLD);
    end

    // Sequencer state, phase counter and the request latched at acceptance.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 2'b00;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
                be_q    <= be;
            end
        end
    end

    // Registered strobe, handshake and pad decode. Address, write data and
    // byte lanes are loaded on entry to SETUP and otherwise hold their value.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            ready      <= 1'b1;
            done       <= 1'b0;
            ram_e_n    <= 1'b1;
            ram_w_n    <= 1'b1;
            ram_g_n    <= 1'b1;
            ram_ub_n   <= 1'b1;
            ram_lb_n   <= 1'b1;
            ram_a      <= '0;
            ram_dq_out <= '0;
            ram_dq_oe  <= 1'b0;
        end else begin
            ready     <= (nxt_state == S_IDLE);
            done      <= (nxt_state == S_DONE);
            ram_e_n   <= !nxt_busy;
            ram_w_n   <= !((nxt_state == S_STROBE) && nxt_we && (nxt_be != 2'b00));
            ram_g_n   <= !((nxt_state == S_STROBE) && !nxt_we);
            ram_dq_oe <= nxt_busy && nxt_we;
            if (accept) begin
                ram_a    <= 16'(nxt_addr);
                ram_ub_n <= !nxt_be[1];
                ram_lb_n <= !nxt_be[0];
                if (nxt_we) begin
                    ram_dq_out <= nxt_wdata;
                end
            end
        end
    end

    // Read data is sampled on the edge that ends the last G_-low cycle.
    // It is presented, lane-masked, only when the operation completes, so
    // rdata keeps the previous read's word until then.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            cap_q <= '0;
            rdata <= '0;
        end else begin
            if ((state == S_STROBE) && last_tick && !we_q) begin
                cap_q <= ram_dq_in;
            end
            if ((state == S_HOLD) && (nxt_state == S_DONE) && !we_q) begin
                rdata <= cap_q & lane_mask;
            end
        end
    end

endmodule

// File: doc/erasable_ram_ctrl.md
# erasable_ram_ctrl

Synchronous initiator for the asynchronous 16-bit erasable SRAM on the fixed/erasable memory board. It accepts single-word read and write requests from the memory-sequencing logic. For each request it generates the SRAM strobe sequence (E_, W_, G_, UB_, LB_, A0–A15, DQ) and returns read data with a completion pulse. W_ and G_ are never driven low together.

## Interface
Parameters:
- ADDR_W, 11: request address width. The SRAM address bits above ADDR_W are driven 0.
- T_SETUP, 1: cycles from address/E_ valid to the strobe falling. Must be ≥1; 0 is an elaboration error.
- T_PULSE, 2: cycles the W_ or G_ strobe is held low. Must be ≥1.
- T_HOLD, 1: cycles after the strobe rises before E_ is released. Must be ≥1.

Ports:
- SIM_CLK  in  1  system clock; all state changes on its rising edge.
- SIM_RST  in  1  asynchronous, active-high reset.
- req  in  1  request valid. Accepted when req && ready.
- we  in  1  1 = write, 0 = read; sampled at acceptance.
- addr  in  ADDR_W  word address; sampled at acceptance.
- wdata  in  16  write word; sampled at acceptance.
- be  in  2  byte enables: bit1 = upper (DQU8–15), bit0 = lower (DQL0–7). Sampled at acceptance.
- ready  out  1  controller idle and able to accept.
- done  out  1  one-cycle pulse when the operation completes.
- rdata  out  16  read word, valid while done=1 for reads. Holds its value until the next read completes.
- ram_e_n, ram_w_n, ram_g_n, ram_ub_n, ram_lb_n  out  1 each  SRAM strobes, active-low.
- ram_a  out  16  SRAM address A15..A0.
- ram_dq_out  out  16  write data to the pads.
- ram_dq_oe  out  1  pad output enable. The board top-level builds the tristate; the DQ inout nets exist only there.
- ram_dq_in  in  16  data sampled from the pads.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, DONE. A down-counter times SETUP, STROBE and HOLD.
- IDLE: ready=1. All strobes high, ram_dq_oe=0. ram_a, ram_dq_out, UB_ and LB_ hold their last values. On acceptance, latch we/addr/wdata/be and go to SETUP.
- SETUP (T_SETUP cycles):
  - ram_e_n=0.
  - ram_a = zero-extended addr.
  - ram_ub_n/ram_lb_n = ~be.
  - Writes only: ram_dq_out=wdata and ram_dq_oe=1.
- STROBE (T_PULSE cycles): writes drive ram_w_n=0; reads drive ram_g_n=0. Reads register ram_dq_in on the final STROBE cycle edge.
- HOLD (T_HOLD cycles):
  - W_ and G_ high.
  - E_, address and write data still driven.
  - ram_dq_oe stays 1 for writes.
- DONE (1 cycle):
  - E_ high, ram_dq_oe=0, done=1, ready=0.
  - rdata = captured word, with the lanes where be=0 forced to 0.
  - Next state is IDLE.
- Write with be=00: the full sequence runs but ram_w_n stays high; done still pulses.
- Read with be=00: G_ still pulses; rdata=0.
- ram_dq_oe and ram_g_n low in the same cycle is forbidden by construction. The output decode is registered, so no glitch can produce that combination.
- req while ready=0 is ignored; the requester must hold req until it is accepted.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE, ready=1, done=0, rdata=0.
  - ram_e_n/w_n/g_n/ub_n/lb_n = 1.
  - ram_a=0, ram_dq_out=0, ram_dq_oe=0.
- Reset mid-operation: strobes go high immediately and the operation is aborted with no done. An interrupted write leaves the target word undefined.
- Latency: acceptance at edge 0. done is high during cycle T_SETUP+T_PULSE+T_HOLD+1, which is cycle 5 with default parameters. ready returns the following cycle.
- Throughput: one operation per T_SETUP+T_PULSE+T_HOLD+2 cycles (6 with defaults).
- All SRAM outputs are registered. Data and address are stable ≥1 cycle before W_/G_ falls and ≥1 cycle after it rises, which covers the SRAM's 30 ns access/propagation delay at a 100 ns clock.

## Test plan
- Reset, then read address 0o0005 with be=11 against the SRAM model -> done in cycle 5, rdata=16'o40000 (the model's power-up contents).
- Write 16'o12345 to 0o1777 with be=11, then read it back -> rdata=16'o12345. W_ is low for exactly 2 cycles. ram_dq_oe=1 from SETUP through HOLD.
- Write 16'hABCD with be=01 to a location holding 16'h1234, then read with be=11 -> UB_ is high during the write, and the bench's lane-masked model gives rdata=16'h12CD. Read with be=10 -> rdata=16'h1200.
- Back-to-back: req held high for 3 writes then 1 read -> accepted exactly 6 cycles apart; W_ and G_ are never both low; ram_dq_oe=0 during every G_-low cycle.
- Assert SIM_RST during a write's STROBE cycle -> ram_w_n and ram_e_n are 1 within the same timestep, no done pulse, ready=1 after reset release.
- Write with be=00 -> ram_w_n stays 1 throughout; done still pulses in cycle 5.
